shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter.sv | 162 ++++++++++++++++
 tb/tb_shift_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/shift_arbiter.sv
// Two-port round-robin front end that time-shares one external 16-bit left barrel shifter.
// Each operation takes three cycles: grant (IDLE), capture (SHIFT), response handshake (RESP).
module shift_arbiter #(
   parameter int unsigned PRIO_RESET = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   output logic [1:0]  req_ready,
   input  logic [15:0] req_data0,
   input  logic [15:0] req_data1,
   input  logic [3:0]  req_amt0,
   input  logic [3:0]  req_amt1,
   output logic [15:0] sh_a,
   output logic [3:0]  sh_s,
   input  logic [15:0] sh_y,
   output logic [1:0]  rsp_valid,
   input  logic [1:0]  rsp_ready,
   output logic [15:0] rsp_data,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      RESP  = 2'd2
   } state_t;

   localparam logic PRIO_BIT = PRIO_RESET[0];

   state_t      state_r;
   state_t      state_s;
   logic        ptr_r;
   logic        owner_r;
   logic        gnt_vld_s;
   logic        gnt_s;
   logic        hs_s;
   logic [1:0]  ready_s;
   logic [15:0] sh_a_r;
   logic [3:0]  sh_s_r;
   logic [15:0] rsp_data_r;
   logic [1:0]  rsp_valid_r;
   logic        busy_r;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (gnt_vld_s) begin
               state_s = SHIFT;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: state_s = RESP;
         RESP: begin
            if (hs_s) begin
               state_s = IDLE;
            end else begin
               state_s = RESP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // Grant selection, accept strobes and response handshake detect
   always_comb begin
      gnt_vld_s = 1'b0;
      gnt_s     = 1'b0;
      ready_s   = 2'b00;
      hs_s      = 1'b0;
      // rst_n gates the accept so nothing is offered while reset is held
      if ((state_r == IDLE) && rst_n) begin
         case (req_valid)
            2'b01: begin
               gnt_vld_s = 1'b1;
               gnt_s     = 1'b0;
            end
            2'b10: begin
               gnt_vld_s = 1'b1;
               gnt_s     = 1'b1;
            end
            2'b11: begin
               gnt_vld_s = 1'b1;
               gnt_s     = ptr_r;
            end
            default: begin
               gnt_vld_s = 1'b0;
               gnt_s     = 1'b0;
            end
         endcase
         if (gnt_vld_s) begin
            ready_s = gnt_s ? 2'b10 : 2'b01;
         end else begin
            ready_s = 2'b00;
         end
      end else begin
         ready_s = 2'b00;
      end
      if (state_r == RESP) begin
         hs_s = rsp_ready[owner_r];
      end else begin
         hs_s = 1'b0;
      end
   end

   // Operand capture for the shared shifter on grant edges only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_a_r  <= 16'h0000;
         sh_s_r  <= 4'h0;
         owner_r <= 1'b0;
      end else if (gnt_vld_s) begin
         sh_a_r  <= gnt_s ? req_data1 : req_data0;
         sh_s_r  <= gnt_s ? req_amt1 : req_amt0;
         owner_r <= gnt_s;
      end
   end

   // Result capture, response valid and round-robin pointer update
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_r  <= 16'h0000;
         rsp_valid_r <= 2'b00;
         ptr_r       <= PRIO_BIT;
      end else if (state_r == SHIFT) begin
         rsp_data_r  <= sh_y;
         rsp_valid_r <= owner_r ? 2'b10 : 2'b01;
      end else if (hs_s) begin
         rsp_valid_r <= 2'b00;
         ptr_r       <= ~owner_r;
      end
   end

   // Busy flag registered from the next state so it tracks state_r exactly
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 1'b0;
      end else begin
         busy_r <= (state_s != IDLE);
      end
   end

   assign req_ready = ready_s;
   assign sh_a      = sh_a_r;
   assign sh_s      = sh_s_r;
   assign rsp_data  = rsp_data_r;
   assign rsp_valid = rsp_valid_r;
   assign busy      = busy_r;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter; the external barrel shifter is modelled inline.
module tb_shift_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [15:0] req_data0;
   logic [15:0] req_data1;
   logic [3:0]  req_amt0;
   logic [3:0]  req_amt1;
   logic [15:0] sh_a;
   logic [3:0]  sh_s;
   logic [15:0] sh_y;
   logic [1:0]  rsp_valid;
   logic [1:0]  rsp_ready;
   logic [15:0] rsp_data;
   logic        busy;

   int total;
   int bad;

   shift_arbiter #(.PRIO_RESET(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data0 (req_data0),
      .req_data1 (req_data1),
      .req_amt0  (req_amt0),
      .req_amt1  (req_amt1),
      .sh_a      (sh_a),
      .sh_s      (sh_s),
      .sh_y      (sh_y),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   assign sh_y = sh_a << sh_s;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      req_data0 = 16'h0000;
      req_data1 = 16'h0000;
      req_amt0  = 4'h0;
      req_amt1  = 4'h0;
      #1;
      chk("rst_ready", 16'(req_ready), 16'h0000);
      chk("rst_rspv",  16'(rsp_valid), 16'h0000);
      chk("rst_sha",   sh_a,           16'h0000);
      chk("rst_shs",   16'(sh_s),      16'h0000);
      chk("rst_rspd",  rsp_data,       16'h0000);
      chk("rst_busy",  16'(busy),      16'h0000);
      step();
      req_valid = 2'b00;
      step();
      rst_n = 1'b1;

      // single operation on port 0
      step();
      req_valid = 2'b01;
      req_data0 = 16'h00F3;
      req_amt0  = 4'h4;
      rsp_ready = 2'b01;
      #1;
      chk("single_ready", 16'(req_ready), 16'h0001);
      chk("single_idle_busy", 16'(busy), 16'h0000);
      step();
      req_valid = 2'b00;
      #1;
      chk("single_shift_ready", 16'(req_ready), 16'h0000);
      chk("single_shift_busy", 16'(busy), 16'h0001);
      chk("single_sha", sh_a, 16'h00F3);
      chk("single_shs", 16'(sh_s), 16'h0004);
      chk("single_shift_rspv", 16'(rsp_valid), 16'h0000);
      step();
      chk("single_rspv", 16'(rsp_valid), 16'h0001);
      chk("single_rspd", rsp_data, 16'h0F30);
      chk("single_resp_ready", 16'(req_ready), 16'h0000);
      step();
      chk("single_done_rspv", 16'(rsp_valid), 16'h0000);
      chk("single_done_busy", 16'(busy), 16'h0000);
      chk("single_hold_sha", sh_a, 16'h00F3);

      // contention and fairness from a fresh reset
      rst_n = 1'b0;
      #1;
      rst_n     = 1'b1;
      req_data0 = 16'h1234;
      req_amt0  = 4'h1;
      req_data1 = 16'h8001;
      req_amt1  = 4'hF;
      rsp_ready = 2'b11;
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fair_ready", 16'(req_ready), (k % 2 == 1) ? 16'h0002 : 16'h0001);
         chk("fair_busy_idle", 16'(busy), 16'h0000);
         step();
         step();
         chk("fair_rspv", 16'(rsp_valid), (k % 2 == 1) ? 16'h0002 : 16'h0001);
         chk("fair_rspd", rsp_data, (k % 2 == 1) ? 16'h8000 : 16'h2468);
         step();
      end
      req_valid = 2'b00;

      // backpressure on port 0, non-owner rsp_ready and new requests ignored
      step();
      req_valid = 2'b01;
      req_data0 = 16'h0F0F;
      req_amt0  = 4'h8;
      rsp_ready = 2'b00;
      #1;
      chk("bp_ready", 16'(req_ready), 16'h0001);
      step();
      req_valid = 2'b10;
      rsp_ready = 2'b10;
      step();
      chk("bp_rspv0", 16'(rsp_valid), 16'h0001);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("bp_rspv", 16'(rsp_valid), 16'h0001);
         chk("bp_rspd", rsp_data, 16'h0F00);
         chk("bp_busy", 16'(busy), 16'h0001);
         chk("bp_ready_low", 16'(req_ready), 16'h0000);
      end
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      step();
      chk("bp_done_rspv", 16'(rsp_valid), 16'h0000);
      chk("bp_done_busy", 16'(busy), 16'h0000);

      // amount zero on port 1
      req_valid = 2'b10;
      req_data1 = 16'hA5C3;
      req_amt1  = 4'h0;
      rsp_ready = 2'b10;
      #1;
      chk("zero_ready", 16'(req_ready), 16'h0002);
      step();
      req_valid = 2'b00;
      step();
      chk("zero_rspv", 16'(rsp_valid), 16'h0002);
      chk("zero_rspd", rsp_data, 16'hA5C3);
      step();
      chk("zero_done_rspv", 16'(rsp_valid), 16'h0000);

      // withdrawn request is never granted
      req_valid = 2'b01;
      req_data0 = 16'h7777;
      #1;
      chk("wd_ready", 16'(req_ready), 16'h0001);
      req_valid = 2'b00;
      step();
      chk("wd_busy", 16'(busy), 16'h0000);
      chk("wd_sha", sh_a, 16'hA5C3);

      // port 0 op moves the pointer to 1, then reset in SHIFT
      req_valid = 2'b01;
      req_data0 = 16'h0001;
      req_amt0  = 4'h3;
      rsp_ready = 2'b01;
      step();
      req_valid = 2'b00;
      step();
      chk("pre_rspd", rsp_data, 16'h0008);
      step();
      req_valid = 2'b11;
      req_data1 = 16'h00FF;
      #1;
      chk("pre_ptr_ready", 16'(req_ready), 16'h0002);
      step();
      chk("pre_shift_busy", 16'(busy), 16'h0001);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_sha",   sh_a,           16'h0000);
      chk("mid_rst_shs",   16'(sh_s),      16'h0000);
      chk("mid_rst_rspd",  rsp_data,       16'h0000);
      chk("mid_rst_rspv",  16'(rsp_valid), 16'h0000);
      chk("mid_rst_busy",  16'(busy),      16'h0000);
      chk("mid_rst_ready", 16'(req_ready), 16'h0000);
      step();
      rst_n     = 1'b1;
      req_valid = 2'b00;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("post_rst_rspv", 16'(rsp_valid), 16'h0000);
         chk("post_rst_busy", 16'(busy), 16'h0000);
      end
      req_valid = 2'b11;
      #1;
      chk("post_rst_ptr", 16'(req_ready), 16'h0001);
      req_valid = 2'b00;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
